// File: rtl/rr_mux_arbiter.sv
// Two-requester burst arbiter with round-robin tie-breaking, a per-grant beat limit
// and a single registered output stage that holds under downstream backpressure.
module rr_mux_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req0_last,
    output logic                  req0_ready,

    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  req1_last,
    output logic                  req1_ready,

    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_src,
    input  logic                  out_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [8:0] BURST_LIMIT = 9'(MAX_BURST);

    state_t                state_q, state_d;
    logic                  rr_q, rr_d;
    logic [7:0]            beatCnt_q, beatCnt_d;
    logic                  outValid_q, outValid_d;
    logic [DATA_WIDTH-1:0] outData_q, outData_d;
    logic                  outSrc_q, outSrc_d;
    logic [1:0]            runSync_q;

    logic                  run;
    logic                  outFree;
    logic                  accept;
    logic                  selLast;
    logic                  selSrc;
    logic [DATA_WIDTH-1:0] selData;
    logic [8:0]            beatNext;
    logic                  burstEnd;

    // Reset asserts asynchronously but releases through two flops, so the first
    // grant decision can only happen on a clean edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            runSync_q <= 2'b00;
        end else begin
            runSync_q <= {runSync_q[0], 1'b1};
        end
    end

    assign run     = runSync_q[1];
    assign outFree = !outValid_q || out_ready;

    assign req0_ready = (state_q == GRANT0) && outFree;
    assign req1_ready = (state_q == GRANT1) && outFree;

    always_comb begin
        accept  = 1'b0;
        selLast = 1'b0;
        selSrc  = 1'b0;
        selData = '0;
        case (state_q)
            GRANT0: begin
                accept  = req0_valid && req0_ready;
                selLast = req0_last;
                selSrc  = 1'b0;
                selData = req0_data;
            end
            GRANT1: begin
                accept  = req1_valid && req1_ready;
                selLast = req1_last;
                selSrc  = 1'b1;
                selData = req1_data;
            end
            default: begin
                accept  = 1'b0;
            end
        endcase
    end

    // A single release covers both the explicit last beat and the beat-limit case.
    assign beatNext = {1'b0, beatCnt_q} + 9'd1;
    assign burstEnd = selLast || (beatNext == BURST_LIMIT);

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        beatCnt_d = beatCnt_q;
        case (state_q)
            IDLE: begin
                beatCnt_d = 8'd0;
                if (req0_valid && req1_valid) begin
                    state_d = rr_q ? GRANT0 : GRANT1;
                end else if (req0_valid) begin
                    state_d = GRANT0;
                end else if (req1_valid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (accept) begin
                    beatCnt_d = beatNext[7:0];
                    if (burstEnd) begin
                        state_d = IDLE;
                        rr_d    = selSrc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The output register only loads when it is empty or draining this cycle,
    // which is exactly when the granted requester sees ready.
    always_comb begin
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outSrc_d   = outSrc_q;
        if (accept) begin
            outValid_d = 1'b1;
            outData_d  = selData;
            outSrc_d   = selSrc;
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_q       <= 1'b1;
            beatCnt_q  <= 8'd0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSrc_q   <= 1'b0;
        end else if (run) begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            beatCnt_q  <= beatCnt_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outSrc_q   <= outSrc_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_src   = outSrc_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: directed bursts push hand-computed beats,
// a negedge monitor pops and compares every output transfer.
module tb_rr_mux_arbiter;

    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          req0_valid, req0_last, req0_ready;
    logic [DW-1:0] req0_data;
    logic          req1_valid, req1_last, req1_ready;
    logic [DW-1:0] req1_data;
    logic          out_valid, out_src, out_ready;
    logic [DW-1:0] out_data;

    rr_mux_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecCount  = 0;
    int missCount = 0;
    int cyc       = 0;
    int acc0      = 0;

    logic [8:0]    expQ[$];
    int            popCyc[$];
    logic [DW-1:0] src0Data[$];
    logic          src0Last[$];
    logic [DW-1:0] src1Data[$];
    logic          src1Last[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output handshake consumes one expected {src,data} entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            vecCount++;
            popCyc.push_back(cyc);
            if (expQ.size() == 0) begin
                missCount++;
                $display("[TB] FAIL unexpected_beat: got src=%0d data=0x%02h, required none", out_src, out_data);
            end else begin
                logic [8:0] expBeat;
                expBeat = expQ.pop_front();
                if ({out_src, out_data} !== expBeat) begin
                    missCount++;
                    $display("[TB] FAIL beat: got src=%0d data=0x%02h, required src=%0d data=0x%02h",
                             out_src, out_data, expBeat[8], expBeat[7:0]);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] required);
        vecCount++;
        if (actual !== required) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
        end
    endtask

    task automatic driveSources();
        req0_valid = (src0Data.size() > 0);
        req0_data  = (src0Data.size() > 0) ? src0Data[0] : '0;
        req0_last  = (src0Last.size() > 0) ? src0Last[0] : 1'b0;
        req1_valid = (src1Data.size() > 0);
        req1_data  = (src1Data.size() > 0) ? src1Data[0] : '0;
        req1_last  = (src1Last.size() > 0) ? src1Last[0] : 1'b0;
    endtask

    task automatic stepCycle();
        logic fire0, fire1;
        @(negedge clk);
        fire0 = req0_valid && req0_ready;
        fire1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
        if (fire0) begin
            void'(src0Data.pop_front());
            void'(src0Last.pop_front());
            acc0++;
        end
        if (fire1) begin
            void'(src1Data.pop_front());
            void'(src1Last.pop_front());
        end
        driveSources();
    endtask

    task automatic applyStimulus(input logic src, input logic [DW-1:0] data, input logic last);
        if (src) begin
            src1Data.push_back(data);
            src1Last.push_back(last);
        end else begin
            src0Data.push_back(data);
            src0Last.push_back(last);
        end
        driveSources();
    endtask

    task automatic expectBeat(input logic src, input logic [DW-1:0] data);
        expQ.push_back({src, data});
    endtask

    task automatic waitDone(input string name);
        int budget;
        budget = 0;
        while ((src0Data.size() > 0 || src1Data.size() > 0 || expQ.size() > 0) && budget < 200) begin
            stepCycle();
            budget++;
        end
        repeat (3) stepCycle();
        vecCount++;
        if (budget >= 200) begin
            missCount++;
            $display("[TB] FAIL %s_timeout: %0d beats still expected, required 0", name, expQ.size());
        end
    endtask

    task automatic clearSources();
        src0Data.delete();
        src0Last.delete();
        src1Data.delete();
        src1Last.delete();
        acc0 = 0;
        driveSources();
    endtask

    task automatic releaseReset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) stepCycle();
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        clearSources();
        expQ.delete();
        releaseReset();
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        clearSources();
        #2;
        checkOutput("rst_out_valid", 16'(out_valid), 16'h0);
        checkOutput("rst_out_data", 16'(out_data), 16'h0);
        checkOutput("rst_out_src", 16'(out_src), 16'h0);
        checkOutput("rst_ready", 16'({req0_ready, req1_ready}), 16'h0);
        releaseReset();

        // Single requester, one beat per cycle.
        popCyc.delete();
        applyStimulus(1'b0, 8'h11, 1'b0);
        applyStimulus(1'b0, 8'h22, 1'b0);
        applyStimulus(1'b0, 8'h33, 1'b1);
        expectBeat(1'b0, 8'h11);
        expectBeat(1'b0, 8'h22);
        expectBeat(1'b0, 8'h33);
        waitDone("single");
        checkOutput("single_spacing", 16'(popCyc[2] - popCyc[0]), 16'd2);

        // Ties alternate starting with req0, one bubble between grants.
        applyReset();
        popCyc.delete();
        applyStimulus(1'b0, 8'hA1, 1'b1);
        applyStimulus(1'b0, 8'hA2, 1'b1);
        applyStimulus(1'b1, 8'hB1, 1'b1);
        applyStimulus(1'b1, 8'hB2, 1'b1);
        expectBeat(1'b0, 8'hA1);
        expectBeat(1'b1, 8'hB1);
        expectBeat(1'b0, 8'hA2);
        expectBeat(1'b1, 8'hB2);
        waitDone("tie");
        checkOutput("tie_spacing", 16'(popCyc[3] - popCyc[0]), 16'd6);

        // Forced release after four beats, req1 served, then req0 resumes.
        applyReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'(8'hC0 + i), (i == 5));
        applyStimulus(1'b1, 8'hD0, 1'b0);
        applyStimulus(1'b1, 8'hD1, 1'b1);
        for (int i = 0; i < 4; i++) expectBeat(1'b0, 8'(8'hC0 + i));
        expectBeat(1'b1, 8'hD0);
        expectBeat(1'b1, 8'hD1);
        expectBeat(1'b0, 8'hC4);
        expectBeat(1'b0, 8'hC5);
        waitDone("forced");

        // Backpressure: output holds and req0 stalls while out_ready is low.
        applyReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'(8'h51 + i), (i == 3));
            expectBeat(1'b0, 8'(8'h51 + i));
        end
        for (int i = 0; i < 20 && !out_valid; i++) stepCycle();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("bp_hold_data", 16'(out_data), 16'h51);
            checkOutput("bp_ready0", 16'(req0_ready), 16'h0);
        end
        out_ready = 1'b1;
        waitDone("backpressure");

        // Reset after beat 2 of 4 discards the burst; next tie goes to req0.
        applyReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'(8'h61 + i), (i == 3));
        expectBeat(1'b0, 8'h61);
        for (int i = 0; i < 20 && acc0 < 2; i++) stepCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 16'(out_valid), 16'h0);
        checkOutput("midrst_out_data", 16'(out_data), 16'h0);
        checkOutput("midrst_ready0", 16'(req0_ready), 16'h0);
        checkOutput("midrst_expq", 16'(expQ.size()), 16'd0);
        clearSources();
        expQ.delete();
        releaseReset();
        applyStimulus(1'b1, 8'hE1, 1'b1);
        applyStimulus(1'b0, 8'hE0, 1'b1);
        expectBeat(1'b0, 8'hE0);
        expectBeat(1'b1, 8'hE1);
        waitDone("post_reset_tie");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 8, width of each requester data bus and of the output data bus.
REQ-002 Parameter: MAX_BURST, 4, maximum beats per grant before forced release; legal range 1..255.
REQ-003 The block SHALL use one clock, `clk`, and an asynchronous active-low reset, `rst_n`.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: req0_valid  input  1  requester 0 offers a beat.
REQ-007 Port: req0_data  input  DATA_WIDTH  requester 0 beat data.
REQ-008 Port: req0_last  input  1  requester 0 beat is the final beat of its burst.
REQ-009 Port: req0_ready  output  1  block accepts requester 0 beat this cycle.
REQ-010 Port: req1_valid, req1_data, req1_last, req1_ready  same as req0_* for requester 1.
REQ-011 Port: out_valid  output  1  registered output beat present.
REQ-012 Port: out_data  output  DATA_WIDTH  registered output beat data.
REQ-013 Port: out_src  output  1  source of the current output beat (0 = req0, 1 = req1).
REQ-014 Port: out_ready  input  1  downstream accepts the output beat.

Function
REQ-015 A transfer SHALL occur on any interface when valid and ready are both high at a rising clk edge.
REQ-016 The FSM SHALL have three states: IDLE, GRANT0 and GRANT1.
REQ-017 IDLE: all reqN_ready SHALL be 0; if exactly one reqN_valid is high, the next state SHALL be GRANTN.
REQ-018 IDLE with both valid: the block SHALL grant the requester opposite to the rr pointer (last-served index); rr resets to 1, so req0 wins the first tie.
REQ-019 GRANTN: reqN_ready SHALL equal (!out_valid | out_ready); the non-granted ready SHALL be 0.
REQ-020 On an accepted beat, out_data/out_src/out_valid SHALL load next cycle (1-cycle latency); out_valid SHALL clear after an output transfer with no new accepted beat.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_src SHALL hold stable (no drop, no overwrite).
REQ-022 A beat counter SHALL clear on entry to GRANTN and increment per accepted beat.
REQ-023 GRANTN SHALL return to IDLE after the accepted beat that has reqN_last=1 or is beat number MAX_BURST; rr SHALL be set to N at that edge.
REQ-024 Both conditions in REQ-023 on the same beat SHALL cause a single release.
REQ-025 Requester valid deasserting mid-grant SHALL NOT release the grant; the grant holds until REQ-023 is satisfied.
REQ-026 Each release SHALL insert exactly one IDLE cycle (grant-to-grant bubble = 1 cycle).
REQ-027 A requester SHALL NOT be granted twice in succession while the other holds valid at release.
REQ-028 Beats in flight SHALL NOT be reordered; the output sequence equals the per-grant accepted order.

Reset
REQ-029 On rst_n low: state=IDLE, rr=1, beat counter=0, out_valid=0, out_data=0, out_src=0, both reqN_ready=0, all applied asynchronously.
REQ-030 Reset asserted mid-burst SHALL discard the registered beat and any partial burst; after deassertion the block SHALL behave as after power-up.
REQ-031 rst_n deassertion SHALL be taken synchronously to clk; the first grant decision SHALL occur no earlier than the first edge after release.

Verification
REQ-032 Single requester: req0 sends 3 beats 0x11,0x22,0x33 with last on 0x33, out_ready=1 -> out shows 0x11,0x22,0x33 with out_src=0, one beat per cycle, then IDLE.
REQ-033 Tie after reset: both valid with single-beat bursts (last=1) -> grant order req0, req1, req0, req1, one IDLE bubble between each grant.
REQ-034 Forced release: MAX_BURST=4, req0 streams 6 beats without last, req1 valid -> 4 beats from req0, then req1 granted, then req0 resumes.
REQ-035 Backpressure: out_ready=0 for 5 cycles during a GRANT0 burst -> out_data holds, req0_ready=0 after one beat buffered, no loss or duplication on resume.
REQ-036 Reset mid-burst: assert rst_n=0 after beat 2 of 4 -> out_valid=0 immediately, state IDLE, rr=1; next tie grants req0.
